uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between N_REQ byte-stream requesters. It accepts bytes over per-requester valid/ready handshakes and issues a one-cycle start pulse with the data to the transmitter. It waits for the transmitter's done tick before scheduling the next byte. It sits between the system-side byte producers and uart_tx, the TX counterpart of uart_rx, and bounds per-owner bursts for fairness.

Parameters:
N_REQ, 4, number of requesters (>=2)
D_BIT, 8, data bits per frame (matches the UART datapath)
MAX_BURST, 1, max consecutive bytes one owner may send before re-arbitration (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
req_valid  input  N_REQ  per-requester byte available
req_data  input  N_REQ*D_BIT  packed bytes; requester i at [i*D_BIT +: D_BIT]
req_ready  output  N_REQ  one-hot, one-cycle pulse: byte of requester i consumed
tx_start  output  1  one-cycle start pulse to the transmitter
tx_din  output  D_BIT  byte to transmit, registered, stable from tx_start until the next tx_start
tx_done_tick  input  1  transmitter finished a frame (stop bits sent)
grant  output  N_REQ  one-hot current owner; 0 in IDLE
gnt_id  output  clog2(N_REQ)  binary index of the current or last owner
busy  output  1  high in START and WAIT

Behaviour:
- Reset: all outputs are 0. State is IDLE, burst_cnt is 0, and rr_ptr is N_REQ-1, so requester 0 has top priority first. Reset mid-frame aborts immediately with no ready or start pulses.
- States:
  - IDLE
    - If req_valid is nonzero, select a winner by round robin. Search starts at rr_ptr+1 mod N_REQ, wrapping around.
    - Register grant and gnt_id, clear burst_cnt, go to START.
    - Otherwise stay in IDLE.
  - START (exactly 1 cycle)
    - tx_start=1 and req_ready[owner]=1.
    - tx_din <= req_data[owner] at this clock edge; the value is visible when tx_start is high.
    - Go to WAIT.
  - WAIT
    - Hold until tx_done_tick=1.
    - On done: if req_valid[owner]=1 and burst_cnt < MAX_BURST-1, increment burst_cnt and go to START (same owner).
    - Otherwise set rr_ptr <= owner, clear grant, go to IDLE.
- Latency:
  - req_valid rising in IDLE at cycle t gives tx_start and req_ready at t+1.
  - tx_done_tick at cycle d gives the next tx_start at d+1 (burst continuation) or d+2 (via IDLE).
- Handshake rules:
  - Requesters hold req_valid and req_data stable until req_ready; dropping valid without ready is a protocol violation (the bench asserts on it).
  - Exactly one req_ready bit is high per tx_start, and never outside START.
- tx_done_tick outside WAIT is ignored.
- A lone requester always re-wins after IDLE, so a continuous stream from one source never stalls; it only gains one IDLE cycle per MAX_BURST bytes.
- Simultaneous requests are resolved purely by rotation order from rr_ptr. With MAX_BURST=1 the order among always-valid requesters is a strict cycle.
- burst_cnt width is clog2(MAX_BURST)+1 and it saturates safely; rr_ptr wraps modulo N_REQ (non-power-of-2 N_REQ supported).
- No combinational path from req_valid to req_ready or tx_start; all outputs come from registers or state decode.

Decomposition:
- Shared package uart_pkg holds:
  - the arbiter state encoding (IDLE, START, WAIT, 2 bits);
  - the D_BIT default;
  - the oversampling constant SB_TICK=16 shared with uart_rx/uart_tx.
- One sub-module, rr_pick: combinational rotate-priority-rotate-back selector.
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner, binary index, any_req.
- The FSM, burst counter and pointer stay in uart_tx_arbiter.

Test Plan:
1. Single requester: req_valid=4'b0001, req_data[7:0]=8'hA5 → next cycle tx_start=1, tx_din=8'hA5, req_ready=4'b0001. Pulse tx_done_tick 20 cycles later → busy=0 and grant=0 the following cycle.
2. Fairness, MAX_BURST=1: all four valid continuously with distinct bytes 8'h10..8'h13 → transmit order is requester 0,1,2,3,0,1. Exactly one req_ready per tx_start.
3. Burst, MAX_BURST=2: requesters 0 and 2 continuously valid → owner sequence 0,0,2,2,0,0. Second byte of each burst has tx_start exactly 1 cycle after tx_done_tick.
4. Valid withdrawn at done: requester 1 valid for one byte only, MAX_BURST=4 → after tx_done_tick goes to IDLE, rr_ptr=1, no extra tx_start.
5. Spurious and reset: tx_done_tick pulsed in IDLE and START is ignored (no state change). Assert rst during WAIT → all outputs 0 immediately. After release, with requesters 1 and 3 valid, grant=4'b0010 first.
6. N_REQ=3 wrap: requester 2 owned last and requesters 0 and 2 valid → next winner is 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART blocks.
//   arb_state_e : uart_tx_arbiter FSM encoding (2 bits)
//   D_BIT_DEF   : default data bits per frame
//   SB_TICK     : baud-tick oversampling factor shared with uart_rx/uart_tx
package uart_pkg;

  localparam int unsigned D_BIT_DEF = 8;
  localparam int unsigned SB_TICK   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i : request vector
//   ptr_i : index of the last winner; the search starts at ptr_i+1 and wraps
//   gnt_o : one-hot winner (all zero when no request)
//   idx_o : binary index of the winner
//   any_o : at least one request present
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Rotate/priority/rotate-back flattened into a scan of positions
  // ptr+1 .. ptr+N, folded back into range with one conditional subtract
  // so non-power-of-2 N needs no modulo.
  always_comb begin
    logic [W:0]   sum;
    logic [W-1:0] pos;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sum = {1'b0, ptr_i} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      pos = sum[W-1:0];
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte producers
// using round-robin arbitration with a bounded per-owner burst.
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : per-requester byte available
//   req_data      : packed bytes, requester i at [i*D_BIT +: D_BIT]
//   req_ready     : one-hot pulse, byte of the owner consumed (START only)
//   tx_start      : one-cycle start pulse to the transmitter
//   tx_din        : registered byte, stable from tx_start to next tx_start
//   tx_done_tick  : transmitter finished a frame (honoured only in WAIT)
//   grant         : one-hot current owner, zero in IDLE
//   gnt_id        : binary index of the current or last owner
//   busy          : high in START and WAIT
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned D_BIT     = D_BIT_DEF,
  parameter int unsigned MAX_BURST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_BIT-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [D_BIT-1:0]           tx_din,
  input  logic                       tx_done_tick,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    gnt_id_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [BW-1:0]    burst_q;
  logic             tx_start_q;
  logic [N_REQ-1:0] req_ready_q;
  logic [D_BIT-1:0] tx_din_q;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             burst_more;
  logic [D_BIT-1:0] data_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_a[g] = req_data[g*D_BIT +: D_BIT];
  end

  rr_pick #(
    .N (N_REQ),
    .W (IW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // One bit wider than the counter so MAX_BURST itself is representable.
  assign burst_more = ({1'b0, burst_q} + (BW+1)'(1)) < (BW+1)'(MAX_BURST);

  // START outputs are registered on the edge that enters START, so tx_din
  // already holds the owner's byte while tx_start is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gnt_id_q    <= '0;
      rr_ptr_q    <= IW'(N_REQ - 1);
      burst_q     <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      tx_din_q    <= '0;
    end else begin
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_gnt;
            gnt_id_q    <= pick_idx;
            burst_q     <= '0;
            tx_start_q  <= 1'b1;
            req_ready_q <= pick_gnt;
            tx_din_q    <= data_a[pick_idx];
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
            if (req_valid[gnt_id_q] && burst_more) begin
              burst_q     <= burst_q + BW'(1);
              tx_start_q  <= 1'b1;
              req_ready_q <= grant_q;
              tx_din_q    <= data_a[gnt_id_q];
              state_q     <= ST_START;
            end else begin
              rr_ptr_q <= gnt_id_q;
              grant_q  <= '0;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_din    = tx_din_q;
  assign grant     = grant_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
